// File: rtl/bus_burst_master.sv
// Burst bus master: turns command/stream requests into framed burst
// transactions on the multiplexed address/data bus ahead of the SDRAM
// controller. Covers arbitration, begin/data/end framing, slave stalls,
// read capture and bus-error aborts. All bus outputs are registered and
// held at zero whenever the master is not driving (wired-OR bus).
module bus_burst_master #(
  parameter int MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdRead,
  input  logic [31:0] cmdAddress,
  input  logic [8:0]  cmdWords,
  input  logic        wrDataValid,
  input  logic [31:0] wrData,
  output logic        wrDataReady,
  output logic        rdDataValid,
  output logic [31:0] rdData,
  output logic        done,
  output logic        error,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        readNotWriteOut,
  output logic        dataValidOut,
  output logic        busyOut,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic        busyIn,
  input  logic        busErrorIn,
  input  logic [31:0] addressDataIn
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_BEGIN = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_WEND  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  localparam logic [8:0] MAX_WORDS = 9'(MAX_BURST);

  logic [2:0]  state;
  logic        is_read;
  logic [31:0] addr;
  logic [8:0]  words;
  logic [8:0]  load_left;    // write words still to pull from the source
  logic [8:0]  accept_left;  // write beats still to be taken by the slave
  logic [9:0]  rd_count;     // read beats captured, saturating

  logic beat_accept;
  logic load_room;
  logic load_fire;
  logic bus_abort;
  logic rd_len_bad;

  // Read data is never back-pressured, so the stall output stays low.
  assign busyOut = 1'b0;

  // Handshake decode: command acceptance, write-register refill, abort.
  always_comb begin
    cmdReady    = (state == S_IDLE);
    beat_accept = (state == S_WDATA) && dataValidOut && !busyIn;
    // The output register can take a new word when it is empty or its
    // current beat leaves this cycle; nothing is taken during an abort so
    // the pending word stays with the source.
    load_room   = (state == S_WDATA) && !busErrorIn && (load_left != 9'd0) &&
                  (!dataValidOut || beat_accept);
    load_fire   = load_room && wrDataValid;
    wrDataReady = load_room;
    bus_abort   = busErrorIn && ((state == S_BEGIN) || (state == S_WDATA) ||
                                 (state == S_WEND)  || (state == S_RDATA));
    // A beat arriving together with the slave's end strobe still counts.
    rd_len_bad  = ((rd_count + {9'd0, dataValidIn}) != {1'b0, words});
  end

  // Transaction sequencer with registered bus and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      is_read             <= 1'b0;
      addr                <= '0;
      words               <= '0;
      load_left           <= '0;
      accept_left         <= '0;
      rd_count            <= '0;
      rdDataValid         <= 1'b0;
      rdData              <= '0;
      done                <= 1'b0;
      error               <= 1'b0;
      requestTransaction  <= 1'b0;
      beginTransactionOut <= 1'b0;
      endTransactionOut   <= 1'b0;
      readNotWriteOut     <= 1'b0;
      dataValidOut        <= 1'b0;
      addressDataOut      <= '0;
      byteEnablesOut      <= '0;
      burstSizeOut        <= '0;
    end else begin
      // Single-cycle strobes default low.
      done                <= 1'b0;
      error               <= 1'b0;
      rdDataValid         <= 1'b0;
      beginTransactionOut <= 1'b0;
      endTransactionOut   <= 1'b0;
      readNotWriteOut     <= 1'b0;
      byteEnablesOut      <= '0;
      burstSizeOut        <= '0;
      if (bus_abort) begin
        // Bus error: release the bus at once and report a failed command.
        requestTransaction <= 1'b0;
        dataValidOut       <= 1'b0;
        addressDataOut     <= '0;
        done               <= 1'b1;
        error              <= 1'b1;
        state              <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmdValid) begin
              is_read <= cmdRead;
              addr    <= {cmdAddress[31:2], 2'b00};
              words   <= cmdWords;
              if ((cmdWords == 9'd0) || (cmdWords > MAX_WORDS)) begin
                done  <= 1'b1;
                error <= 1'b1;
              end else begin
                requestTransaction <= 1'b1;
                state              <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (transactionGranted) begin
              beginTransactionOut <= 1'b1;
              readNotWriteOut     <= is_read;
              addressDataOut      <= addr;
              byteEnablesOut      <= 4'hF;
              burstSizeOut        <= 8'(words - 9'd1);
              load_left           <= words;
              accept_left         <= words;
              rd_count            <= '0;
              state               <= S_BEGIN;
            end
          end
          S_BEGIN: begin
            addressDataOut <= '0;
            state          <= is_read ? S_RDATA : S_WDATA;
          end
          S_WDATA: begin
            if (load_fire) begin
              addressDataOut <= wrData;
              dataValidOut   <= 1'b1;
              load_left      <= load_left - 9'd1;
            end else if (beat_accept) begin
              addressDataOut <= '0;
              dataValidOut   <= 1'b0;
            end
            if (beat_accept) begin
              accept_left <= accept_left - 9'd1;
              if (accept_left == 9'd1) begin
                endTransactionOut <= 1'b1;
                state             <= S_WEND;
              end
            end
          end
          S_WEND: begin
            requestTransaction <= 1'b0;
            done               <= 1'b1;
            state              <= S_IDLE;
          end
          S_RDATA: begin
            if (dataValidIn) begin
              rdData      <= addressDataIn;
              rdDataValid <= 1'b1;
              if (rd_count != '1) rd_count <= rd_count + 10'd1;
            end
            if (endTransactionIn) begin
              requestTransaction <= 1'b0;
              done               <= 1'b1;
              error              <= rd_len_bad;
              state              <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_burst_master.sv
// Scoreboard bench for bus_burst_master: drivers push expected begin
// fields, write beats, read words and done/error outcomes into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_bus_burst_master;
  localparam int MAXB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0, cmdRead = 1'b0;
  logic [31:0] cmdAddress = '0;
  logic [8:0]  cmdWords = '0;
  logic        wrDataValid = 1'b0;
  logic [31:0] wrData = '0;
  logic        transactionGranted = 1'b0, endTransactionIn = 1'b0;
  logic        dataValidIn = 1'b0, busyIn = 1'b0, busErrorIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic        cmdReady, wrDataReady, rdDataValid, done, error;
  logic [31:0] rdData, addressDataOut;
  logic        requestTransaction, beginTransactionOut, endTransactionOut;
  logic        readNotWriteOut, dataValidOut, busyOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;

  bus_burst_master #(.MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRead(cmdRead),
    .cmdAddress(cmdAddress), .cmdWords(cmdWords),
    .wrDataValid(wrDataValid), .wrData(wrData), .wrDataReady(wrDataReady),
    .rdDataValid(rdDataValid), .rdData(rdData), .done(done), .error(error),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .readNotWriteOut(readNotWriteOut), .dataValidOut(dataValidOut), .busyOut(busyOut),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busyIn(busyIn), .busErrorIn(busErrorIn),
    .addressDataIn(addressDataIn)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [44:0] exp_begin[$];
  logic [31:0] exp_wbeat[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] wdata_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected begin-cycle fields: word-aligned address, direction, length-1, all bytes.
  function automatic logic [44:0] begin_fields(input logic rd, input logic [31:0] a, input int n);
    logic [7:0] bs;
    bs = 8'(n - 1);
    return {a & 32'hFFFF_FFFC, rd, bs, 4'hF};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("busy_hold", {dataValidOut, addressDataOut}, {1'b1, prev_data});
      prev_hold = dataValidOut && busyIn && !busErrorIn;
      prev_data = addressDataOut;
      if (beginTransactionOut) begin
        chk("begin_expected", exp_begin.size() > 0, 1);
        if (exp_begin.size() > 0)
          chk("begin_fields", {addressDataOut, readNotWriteOut, burstSizeOut, byteEnablesOut},
              exp_begin.pop_front());
      end
      if (dataValidOut && !busyIn && !busErrorIn) begin
        chk("wbeat_expected", exp_wbeat.size() > 0, 1);
        if (exp_wbeat.size() > 0) chk("write_beat", addressDataOut, exp_wbeat.pop_front());
      end
      if (rdDataValid) begin
        chk("rdata_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("read_data", rdData, exp_rd.pop_front());
      end
      if (done) begin
        chk("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) chk("done_error", error, exp_done.pop_front());
      end else if (error) begin
        chk("error_only_with_done", done, error);
      end
    end
  end

  task automatic issue(input logic rd, input logic [31:0] a, input logic [8:0] n);
    bit ok = 0;
    cmdValid = 1'b1; cmdRead = rd; cmdAddress = a; cmdWords = n;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = cmdReady;
      @(posedge clock); #1;
    end
    cmdValid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", ok, 1);
  endtask

  task automatic run_write(input logic [31:0] a, input int n, input int gdly,
                           input int busy_beat, input int busy_len, input int err_beat,
                           input int busy_pct, input int bubble_pct);
    logic [31:0] w[$];
    int sent = 0, acc = 0, gcnt = 0, busy_left = busy_len, held = 0, cyc = 0;
    bit fin = 0, err_now = 0, err_prev = 0, err_fired = 0;
    if (wdata_q.size() == n) w = wdata_q;
    else for (int i = 0; i < n; i++) w.push_back($urandom);
    wdata_q.delete();
    exp_begin.push_back(begin_fields(1'b0, a, n));
    for (int i = 0; i < n; i++) if (err_beat < 0 || i < err_beat) exp_wbeat.push_back(w[i]);
    exp_done.push_back(err_beat >= 0);
    issue(1'b0, a, 9'(n));
    while (!fin && cyc < 400) begin
      transactionGranted = requestTransaction && (gcnt >= gdly);
      wrDataValid = (sent < n) && ($urandom_range(99) >= bubble_pct);
      wrData = (sent < n) ? w[sent] : 32'h0;
      busyIn = 1'b0;
      if (dataValidOut) begin
        if (acc == busy_beat && busy_left > 0) begin busyIn = 1'b1; busy_left--; end
        else if ($urandom_range(99) < busy_pct) busyIn = 1'b1;
      end
      err_now = dataValidOut && (acc == err_beat) && !err_fired;
      busErrorIn = err_now;
      if (err_now) err_fired = 1;
      @(negedge clock);
      if (err_prev)
        chk("bus_idle_after_error", {requestTransaction, beginTransactionOut, endTransactionOut,
                                     dataValidOut, addressDataOut}, 0);
      if (gcnt > 0 && gcnt < gdly) begin
        chk("request_held", requestTransaction, 1);
        chk("no_begin_before_grant", beginTransactionOut, 0);
      end
      if (requestTransaction) gcnt++;
      if (wrDataValid && wrDataReady) sent++;
      if (dataValidOut && acc == busy_beat) held++;
      if (dataValidOut && !busyIn && !busErrorIn) acc++;
      fin = done;
      err_prev = err_now;
      @(posedge clock); #1;
      cyc++;
    end
    transactionGranted = 1'b0; wrDataValid = 1'b0; busyIn = 1'b0; busErrorIn = 1'b0;
    if (!fin) chk("write_done_timeout", fin, 1);
    if (busy_len > 0 && busy_pct == 0 && err_beat < 0) chk("busy_hold_cycles", held, busy_len + 1);
  endtask

  task automatic run_read(input logic [31:0] a, input int n, input int nret, input int gdly,
                          input bit end_with_last, input int rst_after);
    logic [31:0] r[$];
    int k = 0, gcnt = 0, cyc = 0, wait_rst = -1;
    bit fin = 0, in_data = 0, end_sent = 0, dv;
    for (int i = 0; i < nret; i++) r.push_back($urandom);
    exp_begin.push_back(begin_fields(1'b1, a, n));
    for (int i = 0; i < nret; i++) if (rst_after < 0 || i < rst_after) exp_rd.push_back(r[i]);
    if (rst_after < 0) exp_done.push_back(nret != n);
    issue(1'b1, a, 9'(n));
    while (!fin && cyc < 400) begin
      transactionGranted = requestTransaction && (gcnt >= gdly);
      dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
      if (wait_rst > 0) begin
        wait_rst--;
        if (wait_rst == 0) begin reset = 1'b1; fin = 1; end
      end else if (in_data && !end_sent) begin
        dv = (k < nret) && ($urandom_range(99) < 70);
        if (dv) begin dataValidIn = 1'b1; addressDataIn = r[k]; k++; end
        if (rst_after >= 0) begin
          if (k == rst_after) wait_rst = 3;
        end else if (k == nret && (!dv || end_with_last)) begin
          endTransactionIn = 1'b1;
          end_sent = 1;
        end
      end
      @(negedge clock);
      if (beginTransactionOut) in_data = 1;
      if (requestTransaction) gcnt++;
      fin = fin || done;
      @(posedge clock); #1;
      cyc++;
    end
    transactionGranted = 1'b0; dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
    if (!fin) chk("read_done_timeout", fin, 1);
    if (reset) begin
      @(negedge clock);
      chk("reset_outputs_zero", {requestTransaction, beginTransactionOut, endTransactionOut,
                                 dataValidOut, addressDataOut, rdDataValid, done, error}, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_after_reset", {cmdReady, requestTransaction}, 2'b10);
      @(posedge clock); #1;
    end
  endtask

  task automatic run_reject(input logic [8:0] n);
    bit fin = 0;
    exp_done.push_back(1'b1);
    transactionGranted = 1'b1;
    issue(1'($urandom_range(1)), $urandom, n);
    for (int i = 0; i < 4 && !fin; i++) begin
      @(negedge clock);
      chk("reject_no_request", requestTransaction, 0);
      fin = done;
      @(posedge clock); #1;
    end
    transactionGranted = 1'b0;
    if (!fin) chk("reject_done_timeout", fin, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n, eb, nr;
    @(negedge clock);
    chk("reset_bus_outputs", {requestTransaction, beginTransactionOut, endTransactionOut,
                              readNotWriteOut, dataValidOut, busyOut, addressDataOut,
                              byteEnablesOut, burstSizeOut}, 0);
    chk("reset_status_outputs", {rdDataValid, rdData, done, error, wrDataReady}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_cmd_ready", cmdReady, 1);
    @(posedge clock); #1;

    wdata_q = '{32'h01234567, 32'h89ABCDEF, 32'hAABB5577};
    run_write(32'h0, 3, 0, -1, 0, -1, 0, 0);
    wdata_q = '{32'h01234567, 32'h89ABCDEF, 32'hAABB5577};
    run_write(32'h0, 3, 0, 1, 2, -1, 0, 0);
    run_read(32'h3E8, 16, 16, 0, 1'b1, -1);
    run_read($urandom, 4, 3, 1, 1'b0, -1);
    run_reject(9'd0);
    run_reject(9'd17);
    run_write($urandom, 3, 0, -1, 0, 1, 0, 0);
    run_write($urandom, 4, 1, -1, 0, -1, 20, 20);
    run_write($urandom, 2, 10, -1, 0, -1, 0, 0);
    run_read($urandom, 8, 8, 0, 1'b0, 3);
    run_read($urandom, 5, 7, 2, 1'b1, -1);
    run_write($urandom, MAXB, 0, -1, 0, -1, 30, 30);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(9));
      n = int'($urandom_range(MAXB, 1));
      if (kind == 0) begin
        if ($urandom_range(1) == 0) run_reject(9'd0);
        else run_reject(9'($urandom_range(511, MAXB + 1)));
      end else if (kind < 5) begin
        eb = ($urandom_range(9) == 0) ? int'($urandom_range(n - 1)) : -1;
        run_write($urandom, n, int'($urandom_range(3)), -1, 0, eb, 25, 25);
      end else begin
        nr = ($urandom_range(3) == 0) ? n + int'($urandom_range(2)) - 1 : n;
        run_read($urandom, n, nr, int'($urandom_range(3)), 1'($urandom_range(1)), -1);
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("leftover_begin", exp_begin.size(), 0);
    chk("leftover_wbeat", exp_wbeat.size(), 0);
    chk("leftover_rdata", exp_rd.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
